pattern_detector_param: RTL and testbench

Programmable serial bit-pattern detector for the serial-input front end. It generalises the fixed Moore-style sequence detector to a runtime-loadable pattern of 1..PAT_MAX bits, a selectable overlapping or non-overlapping match mode, a valid-qualified input and a saturating match counter. The match output is registered, so it depends only on state, and it pulses for one cycle after the final pattern bit is sampled. Reset defaults reproduce the legacy 110101 overlapping detector, so existing integrations keep working without configuration.

---
 rtl/pattern_detector_param.sv | 117 +++++++++++
 tb/tb_pattern_detector_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
// Programmable serial bit-pattern detector.
// A runtime-loadable pattern of 1..PAT_MAX bits is compared against a history
// shift register of accepted bits. The match pulse is registered and appears in
// the cycle after the edge that sampled the final pattern bit. Matches are
// counted in a saturating counter. Reset defaults give the legacy 110101
// overlapping detector.
module pattern_detector_param #(
    parameter int                 PAT_MAX = 8,
    parameter int                 CNT_W   = 16,
    parameter logic [PAT_MAX-1:0] RST_PAT = 8'b0011_0101,
    parameter int                 RST_LEN = 6,
    parameter bit                 RST_OVL = 1'b1,
    localparam int                LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               restn,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               ovl_en,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);
    localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_MAX-1:0] act_pat_q, act_pat_d;
    logic [LEN_W-1:0]   act_len_q, act_len_d;
    logic               act_ovl_q, act_ovl_d;
    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Speculative values for the accepted bit, plus the compare mask.
    logic [PAT_MAX-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [PAT_MAX-1:0] len_mask;
    logic               match;

    // Match evaluation on the shifted-in history; bits above act_len are masked off.
    always_comb begin
        hist_n   = {hist_q[PAT_MAX-2:0], in};
        fill_n   = (fill_q >= PAT_MAX_L) ? PAT_MAX_L : fill_q + 1'b1;
        // Shifting all-ones left by act_len leaves ones only above the pattern;
        // a shift of PAT_MAX or more clears it, so the mask covers the full width.
        len_mask = ~({PAT_MAX{1'b1}} << act_len_q);
        match    = in_valid && !cfg_load && (act_len_q != '0) &&
                   (fill_n >= act_len_q) &&
                   (((hist_n ^ act_pat_q) & len_mask) == '0);
    end

    // Next-state for config, history, fill, pulse and counter.
    always_comb begin
        act_pat_d = act_pat_q;
        act_len_d = act_len_q;
        act_ovl_d = act_ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        cnt_d     = cnt_q;
        if (cfg_load) begin
            // A load restarts detection; the bit offered this cycle is dropped.
            act_pat_d = pat;
            act_len_d = (pat_len > PAT_MAX_L) ? PAT_MAX_L : pat_len;
            act_ovl_d = ovl_en;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (match) begin
                out_d = 1'b1;
                if (!act_ovl_q) begin
                    fill_d = '0;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        // Clear wins over a simultaneous increment; the pulse is unaffected.
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset to the legacy config.
    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            act_pat_q <= RST_PAT;
            act_len_q <= RST_LEN_L;
            act_ovl_q <= RST_OVL;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            act_pat_q <= act_pat_d;
            act_len_q <= act_len_d;
            act_ovl_q <= act_ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: two instances (16-bit and 2-bit counter)
// share one stimulus stream. The driver pushes the hand-computed pulse and the
// resulting counts per cycle; the monitor pops and compares at the negedge.
//
// Handshake: the DUT presents {out, match_cnt} once per accepted clock edge;
// every edge driven by the bench carries exactly one expected entry, compared
// on the following falling edge. Reset checks are pushed and signalled by an
// event between edges.
module tb_pattern_detector_param;

    localparam int PAT_MAX = 8;
    localparam int LEN_W   = $clog2(PAT_MAX + 1);

    logic               clk;
    logic               restn;
    logic               in_valid;
    logic               din;
    logic               cfg_load;
    logic [PAT_MAX-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic               ovl_en;
    logic               cnt_clr;
    logic               dout;
    logic [15:0]        cnt16;
    logic               dout2;
    logic [1:0]         cnt2;

    // {out, cnt16, cnt2}
    logic [18:0] exp_q[$];
    string       tag_q[$];
    string       tag;
    event        chk_ev;

    int          vectors;
    int          miscompares;
    logic [15:0] ec;
    logic [1:0]  ec2;

    pattern_detector_param #(.PAT_MAX(PAT_MAX), .CNT_W(16)) dut (
        .clk(clk), .restn(restn), .in_valid(in_valid), .in(din),
        .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .ovl_en(ovl_en),
        .cnt_clr(cnt_clr), .out(dout), .match_cnt(cnt16)
    );

    pattern_detector_param #(.PAT_MAX(PAT_MAX), .CNT_W(2)) dut_sat (
        .clk(clk), .restn(restn), .in_valid(in_valid), .in(din),
        .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .ovl_en(ovl_en),
        .cnt_clr(cnt_clr), .out(dout2), .match_cnt(cnt2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expected entry per presented output and compares.
    initial begin
        logic [18:0] e;
        string       t;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                vectors++;
                if ({dout, cnt16, cnt2} !== e || dout2 !== e[18]) begin
                    miscompares++;
                    $display("FAIL %s: out=%0b/%0b cnt=%0d cnt2=%0d, want out=%0b cnt=%0d cnt2=%0d",
                             t, dout, dout2, cnt16, cnt2, e[18], e[17:2], e[1:0]);
                end
            end
        end
    end

    // Driver: one clock edge, then push the expected response for that edge.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic clr, input logic eo);
        in_valid = v;
        din      = b;
        cfg_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        if (clr) begin
            ec  = '0;
            ec2 = '0;
        end else if (eo) begin
            ec = ec + 1'b1;
            if (ec2 != 2'd3) ec2 = ec2 + 1'b1;
        end
        exp_q.push_back({eo, ec, ec2});
        tag_q.push_back(tag);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic eo);
        drive(1'b1, b, 1'b0, 1'b0, eo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'(($urandom_range(0, 1))), 1'b0, 1'b0, 1'b0);
    endtask

    // Load with a live bit offered (must be discarded), then scramble the
    // config inputs to show they are ignored without cfg_load.
    task automatic load(input logic [PAT_MAX-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        pat     = p;
        pat_len = l;
        ovl_en  = o;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pat     = PAT_MAX'($urandom_range(0, 255));
        pat_len = LEN_W'($urandom_range(0, 15));
        ovl_en  = 1'($urandom_range(0, 1));
    endtask

    // Async reset between edges; the outputs must drop without a clock.
    task automatic async_reset_check();
        #2 restn = 1'b0;
        #1;
        ec  = '0;
        ec2 = '0;
        exp_q.push_back({1'b0, 16'd0, 2'd0});
        tag_q.push_back(tag);
        -> chk_ev;
        @(negedge clk);
        restn = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Directed stimulus
    initial begin
        logic [10:0] s_def;
        logic [10:0] e_def;
        vectors = 0; miscompares = 0; ec = '0; ec2 = '0;
        restn = 1'b0; in_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
        pat = '0; pat_len = '0; ovl_en = 1'b0; cnt_clr = 1'b0;
        tag = "reset";
        repeat (3) @(negedge clk);
        #2;
        exp_q.push_back({1'b0, 16'd0, 2'd0});
        tag_q.push_back(tag);
        -> chk_ev;
        @(negedge clk);
        restn = 1'b1;

        // Default 110101 overlap: stream 11010110101, pulses on bits 6 and 11.
        tag   = "default_110101";
        s_def = 11'b110_1011_0101;
        e_def = 11'b000_0010_0001;
        for (int i = 10; i >= 0; i--) bit_in(s_def[i], e_def[i]);

        // 101 overlapping: 1,0,1,0,1 -> pulses on bits 3 and 5.
        tag = "ovl_101";
        load(8'b101, 4'd3, 1'b1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 1);

        // 101 non-overlapping: single pulse on bit 3.
        tag = "novl_101";
        load(8'b101, 4'd3, 1'b0);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 1); bit_in(0, 0); bit_in(1, 0);

        // Valid gaps of 4 cycles between bits.
        tag = "valid_gaps";
        load(8'b101, 4'd3, 1'b1);
        bit_in(1, 0); idle(4); bit_in(0, 0); idle(4); bit_in(1, 1); idle(2);

        // Load on the completing cycle: no pulse, history and fill restart.
        tag = "load_on_match";
        load(8'b101, 4'd3, 1'b1);
        bit_in(1, 0); bit_in(0, 0);
        load(8'b101, 4'd3, 1'b1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);

        // Length 0 disables detection.
        tag = "len0_random";
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 64; i++) bit_in(1'($urandom_range(0, 1)), 0);

        // Length 15 clamps to 8: pulse only after the 8th bit.
        tag = "len15_clamp";
        load(8'b1010_0110, 4'd15, 1'b1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0);
        bit_in(0, 0); bit_in(1, 0); bit_in(1, 0); bit_in(0, 1);

        // Counter: clear, 5 back-to-back matches (2-bit counter saturates at 3),
        // then clear together with a 6th match.
        tag = "cnt_saturate";
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1, 1);
        tag = "cnt_clr_on_match";
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Async reset right after a pulse, then mid-pattern under defaults.
        tag = "async_reset_pulse";
        bit_in(1, 1);
        async_reset_check();
        tag = "async_reset_mid";
        bit_in(1, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0);
        async_reset_check();
        tag = "after_reset";
        bit_in(1, 0);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 1);

        @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
